// File: rtl/countdown_unit.sv
// Loadable down-counter feeding an external zero comparator; start/ready handshake,
// one-cycle done pulse and step count for the processor controller.
module countdown_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  input  logic             abort,
  input  logic             z,
  output logic [WIDTH-1:0] count,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             ready_q, busy_q, done_q;

  // z comes from the external comparator of count_q; it is tested before any
  // decrement, so the counter can never wrap below zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    steps_d = steps_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = load_val;
          steps_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (z) begin
          state_d = S_DONE;
        end else if (step_en) begin
          count_d = count_q - ONE;
          steps_d = steps_q + ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they remain pure
  // functions of the state register with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      steps_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      steps_q <= steps_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign count = count_q;
  assign steps = steps_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
